reorder_buffer: RTL and testbench

//  8-entry circular reorder buffer of the Tomasulo core. Sits directly downstream of issue:

---
 rtl/reorder_buffer_pkg.sv | 29 ++
 rtl/reorder_buffer_if.sv | 59 +++++
 rtl/reorder_buffer_rob_entry.sv | 48 ++++
 rtl/reorder_buffer.sv | 107 ++++++++++
 tb/tb_reorder_buffer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared ROB sizing, opcode constants and pointer helper
// Shared with the issue and reservation-station blocks.
package reorder_buffer_pkg;

  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 4;
  localparam int CNT_W  = IDX_W + 1;   // count must reach DEPTH itself

  localparam logic [OP_W-1:0] OP_LOAD  = 4'd0;
  localparam logic [OP_W-1:0] OP_STORE = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd3;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd4;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd5;

  typedef logic [IDX_W-1:0]  rob_idx_t;
  typedef logic [DATA_W-1:0] rob_data_t;
  typedef logic [REG_W-1:0]  rob_reg_t;
  typedef logic [OP_W-1:0]   rob_op_t;

  // DEPTH is a power of two, so plain overflow gives the modulo wrap.
  function automatic rob_idx_t idx_inc(input rob_idx_t i);
    return i + rob_idx_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue/CDB/lookup/commit signal bundle of the reorder buffer
// master: issue/CDB/retire side (drives requests), slave: the reorder buffer.
//   alloc_*  : allocation request and granted tag
//   busy_rb  : per-entry busy flags
//   cdb_*    : result broadcast
//   lk_*     : two operand lookups
//   commit_* : in-order retirement handshake
//   flush    : squash everything
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic       alloc_valid;
  rob_op_t    alloc_op;
  rob_reg_t   alloc_dest;
  logic       alloc_ready;
  rob_idx_t   alloc_idx;
  logic [DEPTH-1:0] busy_rb;

  logic       cdb_valid;
  rob_idx_t   cdb_idx;
  rob_data_t  cdb_data;

  rob_idx_t   lk_idx_a;
  rob_idx_t   lk_idx_b;
  logic       lk_rdy_a;
  logic       lk_rdy_b;
  rob_data_t  lk_val_a;
  rob_data_t  lk_val_b;

  logic       commit_valid;
  logic       commit_ready;
  rob_idx_t   commit_idx;
  rob_reg_t   commit_dest;
  rob_data_t  commit_value;
  logic       commit_store;

  logic       flush;

  modport master (
    output alloc_valid, alloc_op, alloc_dest,
    output cdb_valid, cdb_idx, cdb_data,
    output lk_idx_a, lk_idx_b,
    output commit_ready, flush,
    input  alloc_ready, alloc_idx, busy_rb,
    input  lk_rdy_a, lk_rdy_b, lk_val_a, lk_val_b,
    input  commit_valid, commit_idx, commit_dest, commit_value, commit_store
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_dest,
    input  cdb_valid, cdb_idx, cdb_data,
    input  lk_idx_a, lk_idx_b,
    input  commit_ready, flush,
    output alloc_ready, alloc_idx, busy_rb,
    output lk_rdy_a, lk_rdy_b, lk_val_a, lk_val_b,
    output commit_valid, commit_idx, commit_dest, commit_value, commit_store
  );

endinterface

// File: rtl/reorder_buffer_rob_entry.sv
// rtl/reorder_buffer_rob_entry.sv - one reorder buffer entry (busy/ready/op/dest/value)
// Ports: clk, rst_n, flush (clear all), alloc + alloc_op/alloc_dest (claim entry),
//        retire (free entry), cdb_we + cdb_data (capture result), busy/ready/op/dest/value out.
module rob_entry
  import reorder_buffer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      alloc,
  input  rob_op_t   alloc_op,
  input  rob_reg_t  alloc_dest,
  input  logic      retire,
  input  logic      cdb_we,
  input  rob_data_t cdb_data,
  output logic      busy,
  output logic      ready,
  output rob_op_t   op,
  output rob_reg_t  dest,
  output rob_data_t value
);

  // Priority: flush > alloc > retire > cdb. Alloc and retire never target the
  // same entry in one cycle (that needs a full buffer, where alloc is refused);
  // alloc beating cdb keeps a stale broadcast from marking a fresh entry ready.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      busy  <= 1'b0;
      ready <= 1'b0;
      op    <= '0;
      dest  <= '0;
      value <= '0;
    end else if (alloc) begin
      busy  <= 1'b1;
      ready <= 1'b0;
      op    <= alloc_op;
      dest  <= alloc_dest;
      value <= '0;
    end else if (retire) begin
      busy  <= 1'b0;
      ready <= 1'b0;
    end else if (cdb_we && busy) begin
      value <= cdb_data;
      ready <= 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 8-entry circular reorder buffer with in-order retirement
// Ports: clk, rst_n (sync, active-low), rob (reorder_buffer_if.slave): allocation,
//        busy flags, CDB capture, two combinational operand lookups, commit handshake, flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  reorder_buffer_if.slave rob
);

  rob_idx_t          head;
  rob_idx_t          tail;
  logic [CNT_W-1:0]  count;

  logic [DEPTH-1:0]  busy_vec;
  logic [DEPTH-1:0]  ready_vec;
  rob_op_t           op_arr    [DEPTH];
  rob_reg_t          dest_arr  [DEPTH];
  rob_data_t         value_arr [DEPTH];

  logic accept;
  logic do_commit;

  // Occupancy is judged from registered count only; a commit in the same
  // cycle does not free a slot for a same-cycle allocation.
  assign rob.alloc_ready = (count != CNT_W'(DEPTH));
  assign rob.alloc_idx   = tail;
  assign rob.busy_rb     = busy_vec;

  assign accept    = rob.alloc_valid && rob.alloc_ready;
  assign do_commit = rob.commit_valid && rob.commit_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    rob_entry u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (rob.flush),
      .alloc      (accept && (tail == rob_idx_t'(i))),
      .alloc_op   (rob.alloc_op),
      .alloc_dest (rob.alloc_dest),
      .retire     (do_commit && (head == rob_idx_t'(i))),
      .cdb_we     (rob.cdb_valid && (rob.cdb_idx == rob_idx_t'(i))),
      .cdb_data   (rob.cdb_data),
      .busy       (busy_vec[i]),
      .ready      (ready_vec[i]),
      .op         (op_arr[i]),
      .dest       (dest_arr[i]),
      .value      (value_arr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || rob.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept)    tail <= idx_inc(tail);
      if (do_commit) head <= idx_inc(head);
      case ({accept, do_commit})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Commit uses registered ready, so a result needs one cycle in the entry
  // before it can retire.
  assign rob.commit_valid = busy_vec[head] & ready_vec[head];
  assign rob.commit_idx   = head;
  assign rob.commit_dest  = dest_arr[head];
  assign rob.commit_value = value_arr[head];
  assign rob.commit_store = (op_arr[head] == OP_STORE);

  // Lookups bypass a same-cycle CDB broadcast to a busy entry so issue does
  // not miss a result that lands while it is reading operands.
  always_comb begin
    rob.lk_rdy_a = 1'b0;
    rob.lk_val_a = '0;
    if (busy_vec[rob.lk_idx_a]) begin
      if (rob.cdb_valid && (rob.cdb_idx == rob.lk_idx_a)) begin
        rob.lk_rdy_a = 1'b1;
        rob.lk_val_a = rob.cdb_data;
      end else if (ready_vec[rob.lk_idx_a]) begin
        rob.lk_rdy_a = 1'b1;
        rob.lk_val_a = value_arr[rob.lk_idx_a];
      end
    end
  end

  always_comb begin
    rob.lk_rdy_b = 1'b0;
    rob.lk_val_b = '0;
    if (busy_vec[rob.lk_idx_b]) begin
      if (rob.cdb_valid && (rob.cdb_idx == rob.lk_idx_b)) begin
        rob.lk_rdy_b = 1'b1;
        rob.lk_val_b = rob.cdb_data;
      end else if (ready_vec[rob.lk_idx_b]) begin
        rob.lk_rdy_b = 1'b1;
        rob.lk_val_b = value_arr[rob.lk_idx_b];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized bench for reorder_buffer against a queue model
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Program-order model: q[0] is the oldest in-flight instruction.
  typedef struct {
    int          tag;
    logic [3:0]  op;
    logic [4:0]  dest;
    bit          rdy;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  int   head  = 0;
  bit   armed = 1'b0;

  task automatic model_lookup(input int t, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    foreach (q[k]) begin
      if (q[k].tag == t) begin
        if (bus.cdb_valid && int'(bus.cdb_idx) == t) begin
          r = 1'b1;
          v = bus.cdb_data;
        end else if (q[k].rdy) begin
          r = 1'b1;
          v = q[k].val;
        end
      end
    end
  endtask

  logic [7:0]  exp_busy;
  bit          exp_cv;
  bit          lr;
  logic [31:0] lv;
  bit          acc;
  bit          com;
  int          new_tag;

  always @(negedge clk) begin
    exp_cv = (q.size() != 0) && q[0].rdy;
    if (armed) begin
      exp_busy = '0;
      foreach (q[k]) exp_busy[q[k].tag] = 1'b1;
      chk("alloc_ready", 32'(bus.alloc_ready), 32'(q.size() < 8));
      chk("alloc_idx", 32'(bus.alloc_idx), 32'((head + q.size()) % 8));
      chk("busy_rb", 32'(bus.busy_rb), 32'(exp_busy));
      chk("commit_valid", 32'(bus.commit_valid), 32'(exp_cv));
      chk("commit_idx", 32'(bus.commit_idx), 32'(head));
      if (exp_cv) begin
        chk("commit_dest", 32'(bus.commit_dest), 32'(q[0].dest));
        chk("commit_value", bus.commit_value, q[0].val);
        chk("commit_store", 32'(bus.commit_store), 32'(q[0].op == OP_STORE));
      end
      model_lookup(int'(bus.lk_idx_a), lr, lv);
      chk("lk_rdy_a", 32'(bus.lk_rdy_a), 32'(lr));
      chk("lk_val_a", bus.lk_val_a, lv);
      model_lookup(int'(bus.lk_idx_b), lr, lv);
      chk("lk_rdy_b", 32'(bus.lk_rdy_b), 32'(lr));
      chk("lk_val_b", bus.lk_val_b, lv);
    end
    // Advance the model with the inputs that the next rising edge will see.
    if (!rst_n || bus.flush) begin
      q.delete();
      head  = 0;
      armed = 1'b1;
    end else if (armed) begin
      acc = bus.alloc_valid && (q.size() < 8);
      com = exp_cv && bus.commit_ready;
      new_tag = (head + q.size()) % 8;
      if (bus.cdb_valid)
        foreach (q[k])
          if (q[k].tag == int'(bus.cdb_idx)) begin
            q[k].rdy = 1'b1;
            q[k].val = bus.cdb_data;
          end
      if (com) begin
        void'(q.pop_front());
        head = (head + 1) % 8;
      end
      if (acc) q.push_back('{tag: new_tag, op: bus.alloc_op, dest: bus.alloc_dest, rdy: 1'b0, val: 32'h0});
    end
  end

  task automatic idle();
    bus.alloc_valid  = 1'b0;
    bus.alloc_op     = '0;
    bus.alloc_dest   = '0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_idx      = '0;
    bus.cdb_data     = '0;
    bus.lk_idx_a     = '0;
    bus.lk_idx_b     = '0;
    bus.commit_ready = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb(input int t, input logic [31:0] d);
    bus.cdb_valid = 1'b1;
    bus.cdb_idx   = 3'(t);
    bus.cdb_data  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset then idle
    repeat (10) begin
      #1;
      chk("idle_alloc_ready", 32'(bus.alloc_ready), 32'd1);
      chk("idle_busy_rb", 32'(bus.busy_rb), 32'h00);
      chk("idle_commit_valid", 32'(bus.commit_valid), 32'd0);
      tick();
    end

    // Fill with ADD dest 1..8
    for (int i = 0; i < 8; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_op    = OP_ADD;
      bus.alloc_dest  = 5'(i + 1);
      #1 chk("fill_alloc_idx", 32'(bus.alloc_idx), 32'(i));
      tick();
    end
    bus.alloc_dest = 5'd9;
    #1;
    chk("full_busy_rb", 32'(bus.busy_rb), 32'hFF);
    chk("full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    tick();
    idle();
    #1 chk("full_tail_stays", 32'(bus.alloc_idx), 32'd0);

    // Out-of-order results, in-order retirement
    cdb(2, 32'h22);
    tick();
    idle();
    cdb(0, 32'h10);
    #1 chk("ooo_not_yet", 32'(bus.commit_valid), 32'd0);
    tick();
    idle();
    cdb(1, 32'h11);
    #1;
    chk("hold_cv", 32'(bus.commit_valid), 32'd1);
    chk("hold_idx", 32'(bus.commit_idx), 32'd0);
    tick();
    idle();
    #1;
    chk("hold_cv2", 32'(bus.commit_valid), 32'd1);
    chk("hold_idx2", 32'(bus.commit_idx), 32'd0);
    tick();

    // Full: commit and alloc together -> commit only
    bus.commit_ready = 1'b1;
    bus.alloc_valid  = 1'b1;
    bus.alloc_op     = OP_SUB;
    bus.alloc_dest   = 5'd20;
    #1;
    chk("edge_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    chk("edge_commit_val0", bus.commit_value, 32'h10);
    chk("edge_commit_dest0", 32'(bus.commit_dest), 32'd1);
    tick();
    bus.commit_ready = 1'b0;
    #1;
    chk("wrap_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("wrap_alloc_idx", 32'(bus.alloc_idx), 32'd0);
    tick();
    idle();
    bus.commit_ready = 1'b1;
    #1;
    chk("refull_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    chk("commit1_idx", 32'(bus.commit_idx), 32'd1);
    chk("commit1_val", bus.commit_value, 32'h11);
    tick();
    #1;
    chk("commit2_idx", 32'(bus.commit_idx), 32'd2);
    chk("commit2_val", bus.commit_value, 32'h22);
    chk("commit2_dest", 32'(bus.commit_dest), 32'd3);
    tick();
    idle();

    // Lookup bypass and busy-unready lookup
    cdb(3, 32'hABCD);
    bus.lk_idx_a = 3'd3;
    bus.lk_idx_b = 3'd4;
    #1;
    chk("bypass_rdy_a", 32'(bus.lk_rdy_a), 32'd1);
    chk("bypass_val_a", bus.lk_val_a, 32'hABCD);
    chk("unready_rdy_b", 32'(bus.lk_rdy_b), 32'd0);
    chk("unready_val_b", bus.lk_val_b, 32'd0);
    tick();
    idle();
    bus.commit_ready = 1'b1;
    #1 chk("commit3_val", bus.commit_value, 32'hABCD);
    tick();
    idle();

    // Flush with five entries and a pending CDB
    #1 chk("pre_flush_busy", 32'(bus.busy_rb), 32'hF1);
    bus.flush       = 1'b1;
    bus.alloc_valid = 1'b1;
    cdb(4, 32'h55);
    tick();
    idle();
    #1;
    chk("flush_busy_rb", 32'(bus.busy_rb), 32'h00);
    chk("flush_alloc_idx", 32'(bus.alloc_idx), 32'd0);
    chk("flush_commit_valid", 32'(bus.commit_valid), 32'd0);
    bus.alloc_valid = 1'b1;
    bus.alloc_op    = OP_STORE;
    bus.alloc_dest  = 5'd0;
    tick();
    idle();
    cdb(0, 32'h77);
    tick();
    idle();
    bus.commit_ready = 1'b1;
    #1;
    chk("store_cv", 32'(bus.commit_valid), 32'd1);
    chk("store_flag", 32'(bus.commit_store), 32'd1);
    chk("store_val", bus.commit_value, 32'h77);
    tick();
    idle();

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      rst_n            = ($urandom_range(0, 199) != 0);
      bus.flush        = ($urandom_range(0, 99) == 0);
      bus.alloc_valid  = ($urandom_range(0, 9) < 6);
      bus.alloc_op     = 4'($urandom_range(0, 5));
      bus.alloc_dest   = 5'($urandom);
      bus.cdb_valid    = ($urandom_range(0, 1) == 1);
      bus.cdb_idx      = 3'($urandom_range(0, 7));
      bus.cdb_data     = $urandom;
      bus.lk_idx_a     = 3'($urandom_range(0, 7));
      bus.lk_idx_b     = ($urandom_range(0, 1) == 1) ? bus.cdb_idx : 3'($urandom_range(0, 7));
      bus.commit_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
